// File: rtl/data_o_capture_pkg.sv
// Shared defaults, event record type and sizing helper for the data_o_capture monitor.
package data_o_capture_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int TS_W_DEF  = 16;

    typedef struct packed {
        logic [7:0]          val;
        logic [TS_W_DEF-1:0] ts;
    } evt_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/data_o_capture_fifo.sv
// Synchronous show-ahead FIFO: registered pointers/count, head read combinationally from storage.
module data_o_capture_fifo
    import data_o_capture_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int W     = 8 + TS_W_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        clr_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [W-1:0]                din_i,
    output logic [W-1:0]                dout_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic                        drop_o,
    output logic [cnt_width(DEPTH)-1:0] cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt == '0);
    assign full_o  = (cnt == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !do_push;
    assign cnt_o   = cnt;
    assign dout_o  = empty_o ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i && !rst_i) mem[wr_ptr] <= din_i;
    end

endmodule

// File: rtl/data_o_capture.sv
// Change monitor on an 8-bit bus: each new value is queued with its sample timestamp.
// Define DATA_O_CAPTURE_FILTER_EN to report only values stable for two consecutive samples.
module data_o_capture
    import data_o_capture_pkg::*;
#(
    parameter int         DEPTH    = DEPTH_DEF,
    parameter int         TS_W     = TS_W_DEF,
    parameter logic [7:0] INIT_VAL = 8'h00
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [7:0]                  data_i,
    input  logic                        en_i,
    input  logic                        clr_i,
    input  logic                        rd_i,
    output logic                        evt_valid_o,
    output logic [7:0]                  evt_data_o,
    output logic [TS_W-1:0]             evt_time_o,
    output logic                        ovf_o,
    output logic [cnt_width(DEPTH)-1:0] cnt_o
);

    logic [TS_W-1:0]   ts;
    logic [7:0]        cur_p0;
    logic [TS_W-1:0]   ts_p0;
    logic              chg;
    logic [7:0]        evt_val;
    logic [TS_W-1:0]   evt_ts;
    logic              push;
    logic              empty;
    logic              full;
    logic              drop;
    logic [8+TS_W-1:0] head;

`ifdef DATA_O_CAPTURE_FILTER_EN
    logic [7:0]      mid_p1;
    logic [TS_W-1:0] ts_p1;
    logic [7:0]      prev_p2;

    // Sample stage: cur -> mid -> prev shift chain with the timestamp of each sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts      <= '0;
            cur_p0  <= INIT_VAL;
            ts_p0   <= '0;
            mid_p1  <= INIT_VAL;
            ts_p1   <= '0;
            prev_p2 <= INIT_VAL;
        end else begin
            ts      <= ts + 1'b1;
            cur_p0  <= data_i;
            ts_p0   <= ts;
            mid_p1  <= cur_p0;
            ts_p1   <= ts_p0;
            prev_p2 <= mid_p1;
        end
    end

    // The event is stamped with the first sample of the new value, held in mid.
    assign chg     = (cur_p0 == mid_p1) && (mid_p1 != prev_p2);
    assign evt_val = mid_p1;
    assign evt_ts  = ts_p1;
`else
    logic [7:0] prev_p1;

    // Sample stage: cur -> prev with the timestamp of the current sample.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts      <= '0;
            cur_p0  <= INIT_VAL;
            ts_p0   <= '0;
            prev_p1 <= INIT_VAL;
        end else begin
            ts      <= ts + 1'b1;
            cur_p0  <= data_i;
            ts_p0   <= ts;
            prev_p1 <= cur_p0;
        end
    end

    assign chg     = (cur_p0 != prev_p1);
    assign evt_val = cur_p0;
    assign evt_ts  = ts_p0;
`endif

    // Push stage: enable is sampled at the edge that enqueues the event.
    assign push = chg && en_i;

    data_o_capture_fifo #(
        .DEPTH (DEPTH),
        .W     (8 + TS_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (clr_i),
        .push_i  (push),
        .pop_i   (rd_i),
        .din_i   ({evt_val, evt_ts}),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .drop_o  (drop),
        .cnt_o   (cnt_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            ovf_o <= 1'b0;
        end else if (drop && full) begin
            ovf_o <= 1'b1;
        end
    end

    assign evt_valid_o = !empty;
    assign evt_data_o  = head[8+TS_W-1:TS_W];
    assign evt_time_o  = head[TS_W-1:0];

endmodule

// File: tb/tb_data_o_capture.sv
// Bench for data_o_capture: vector table, directed corner sequences, random run against a queue model.
module tb_data_o_capture;
    import data_o_capture_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = cnt_width(DEPTH);
`ifdef DATA_O_CAPTURE_FILTER_EN
    localparam bit FILT = 1'b1;
    localparam int LAT  = 3;
    localparam int HOLD = 2;
`else
    localparam bit FILT = 1'b0;
    localparam int LAT  = 2;
    localparam int HOLD = 1;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i, en_i, clr_i, rd_i;
    logic [7:0]    data_i;
    logic          valid_a, ovf_a, valid_b, ovf_b;
    logic [7:0]    data_a, data_b;
    logic [15:0]   time_a;
    logic [3:0]    time_b;
    logic [CW-1:0] cnt_a, cnt_b;

    data_o_capture #(.DEPTH(DEPTH), .TS_W(16), .INIT_VAL(8'h00)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .en_i(en_i), .clr_i(clr_i), .rd_i(rd_i),
        .evt_valid_o(valid_a), .evt_data_o(data_a), .evt_time_o(time_a), .ovf_o(ovf_a), .cnt_o(cnt_a));

    data_o_capture #(.DEPTH(DEPTH), .TS_W(4), .INIT_VAL(8'h00)) u_dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .en_i(en_i), .clr_i(clr_i), .rd_i(rd_i),
        .evt_valid_o(valid_b), .evt_data_o(data_b), .evt_time_o(time_b), .ovf_o(ovf_b), .cnt_o(cnt_b));

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: history of samples (newest first) and a queue of pending events.
    typedef struct {
        logic [7:0]  v;
        int unsigned t;
    } mevt_t;

    mevt_t       samp[$];
    mevt_t       q[$];
    bit          m_ovf;
    int unsigned m_ts;

    task automatic model_edge();
        bit    chg;
        mevt_t ev;
        bit    popd;
        if (rst_i) begin
            q.delete();
            samp.delete();
            for (int i = 0; i < 3; i++) samp.push_back('{v: 8'h00, t: 0});
            m_ovf = 0;
            m_ts  = 0;
            return;
        end
        if (FILT) begin
            chg = (samp[0].v == samp[1].v) && (samp[1].v != samp[2].v);
            ev  = samp[1];
        end else begin
            chg = (samp[0].v != samp[1].v);
            ev  = samp[0];
        end
        popd = rd_i && (q.size() > 0);
        if (clr_i) begin
            q.delete();
            m_ovf = 0;
        end else begin
            if (popd) void'(q.pop_front());
            if (chg && en_i) begin
                if (q.size() < DEPTH) q.push_back(ev);
                else m_ovf = 1;
            end
        end
        samp.push_front('{v: data_i, t: m_ts});
        void'(samp.pop_back());
        m_ts++;
    endtask

    task automatic check_model();
        bit          ev;
        logic [7:0]  ed;
        int unsigned et;
        ev = (q.size() > 0);
        ed = ev ? q[0].v : 8'h00;
        et = ev ? q[0].t : 0;
        chk("m_valid", valid_a, ev);
        chk("m_data", data_a, ed);
        chk("m_time16", time_a, et & 32'hFFFF);
        chk("m_cnt", cnt_a, q.size());
        chk("m_ovf", ovf_a, m_ovf);
        chk("m_valid4", valid_b, ev);
        chk("m_time4", time_b, et & 32'hF);
        chk("m_cnt4", cnt_b, q.size());
        chk("m_ovf4", ovf_b, m_ovf);
    endtask

    task automatic step(input bit r, input logic [7:0] d, input bit e, input bit c, input bit rd);
        rst_i = r; data_i = d; en_i = e; clr_i = c; rd_i = rd;
        @(posedge clk_i);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        bit         rst;
        logic [7:0] d;
        bit         en, clr, rd;
        bit         ev;
        int         cnt;
        logic [7:0] ed;
        int         et;
        bit         ovf;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  tog_v;
        int          tog;
        int unsigned prev_t;
        bit          reached;

        rst_i = 1'b1; data_i = 8'h00; en_i = 1'b1; clr_i = 1'b0; rd_i = 1'b0;

        // Vector table: reset, first change at ts=5, pop, changes while disabled.
        tbl[0] = '{1, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0};
        for (int i = 1; i <= 5; i++) tbl[i] = '{0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0};
        tbl[6] = '{0, 8'h01, 1, 0, 0, 0, 0, 8'h00, 0, 0};
        if (FILT) tbl[7] = '{0, 8'h01, 1, 0, 0, 0, 0, 8'h00, 0, 0};
        else      tbl[7] = '{0, 8'h01, 1, 0, 0, 1, 1, 8'h01, 5, 0};
        tbl[8]  = '{0, 8'h01, 1, 0, 0, 1, 1, 8'h01, 5, 0};
        tbl[9]  = '{0, 8'h01, 1, 0, 1, 0, 0, 8'h00, 0, 0};
        tbl[10] = '{0, 8'h01, 1, 0, 0, 0, 0, 8'h00, 0, 0};
        tbl[11] = '{0, 8'h02, 0, 0, 0, 0, 0, 8'h00, 0, 0};
        tbl[12] = '{0, 8'h02, 0, 0, 0, 0, 0, 8'h00, 0, 0};
        tbl[13] = '{0, 8'h02, 0, 0, 0, 0, 0, 8'h00, 0, 0};
        tbl[14] = '{0, 8'h02, 1, 0, 0, 0, 0, 8'h00, 0, 0};
        tbl[15] = '{0, 8'h02, 1, 1, 0, 0, 0, 8'h00, 0, 0};
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].d, tbl[i].en, tbl[i].clr, tbl[i].rd);
            chk($sformatf("tbl%0d_valid", i), valid_a, tbl[i].ev);
            chk($sformatf("tbl%0d_cnt", i), cnt_a, tbl[i].cnt);
            chk($sformatf("tbl%0d_data", i), data_a, tbl[i].ed);
            chk($sformatf("tbl%0d_time", i), time_a, tbl[i].et);
            chk($sformatf("tbl%0d_ovf", i), ovf_a, tbl[i].ovf);
        end

        // Constant bus after reset: nothing queued.
        step(1, 8'h00, 1, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 8'h00, 1, 0, 0);
            chk("idle_valid", valid_a, 0);
            chk("idle_cnt", cnt_a, 0);
            chk("idle_ovf", ovf_a, 0);
        end

        // Overflow: 12 changes without reads, then flush.
        step(1, 8'h00, 1, 0, 0);
        for (int i = 0; i < 24; i++) step(0, ((i / 2) % 2 == 0) ? 8'h01 : 8'h02, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h02, 1, 0, 0);
        chk("ovf_cnt", cnt_a, DEPTH);
        chk("ovf_flag", ovf_a, 1);
        chk("ovf_head_data", data_a, 8'h01);
        chk("ovf_head_time", time_a, 0);
        step(0, 8'h02, 1, 1, 0);
        chk("clr_cnt", cnt_a, 0);
        chk("clr_ovf", ovf_a, 0);
        chk("clr_valid", valid_a, 0);

        // Refill to full, then read every cycle while changes continue.
        tog = 0;
        reached = 0;
        for (int i = 0; i < 64 && !reached; i++) begin
            tog_v = ((tog / HOLD) % 2 == 0) ? 8'h01 : 8'h02;
            tog++;
            step(0, tog_v, 1, 0, 0);
            reached = (cnt_a == DEPTH);
        end
        chk("fill_reached", reached, 1);
        chk("fill_ovf", ovf_a, 0);
        for (int i = 0; i < 10; i++) begin
            prev_t = time_a;
            tog_v = ((tog / HOLD) % 2 == 0) ? 8'h01 : 8'h02;
            tog++;
            step(0, tog_v, 1, 0, 1);
            if (!FILT) chk("drain_cnt", cnt_a, DEPTH);
            chk("drain_ovf", ovf_a, 0);
            chk("drain_order", (time_a > prev_t), 1);
        end

        // Timestamp wrap on the 4-bit instance: events at ts 14 and 17.
        step(1, 8'h00, 1, 0, 0);
        for (int i = 0; i < 14; i++) step(0, 8'h00, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h11, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h22, 1, 0, 0);
        chk("wrap_cnt", cnt_b, 2);
        chk("wrap_t4_first", time_b, 14);
        chk("wrap_t16_first", time_a, 14);
        chk("wrap_data_first", data_b, 8'h11);
        step(0, 8'h22, 1, 0, 1);
        chk("wrap_t4_second", time_b, 1);
        chk("wrap_t16_second", time_a, 17);
        chk("wrap_data_second", data_b, 8'h22);

        // One-cycle glitch, then a held change and its latency.
        step(1, 8'h00, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'hAA, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
        chk("glitch_cnt", cnt_a, FILT ? 0 : 2);
        chk("glitch_head", data_a, FILT ? 8'h00 : 8'hAA);
        step(0, 8'h00, 1, 0, 1);
        chk("glitch_cnt_pop", cnt_a, FILT ? 0 : 1);
        chk("glitch_second", data_a, 8'h00);
        step(0, 8'h00, 1, 1, 0);
        step(0, 8'hAA, 1, 0, 0);
        chk("held_lat0", valid_a, 0);
        for (int k = 1; k < LAT; k++) begin
            step(0, 8'hAA, 1, 0, 0);
            chk($sformatf("held_lat%0d", k), valid_a, (k == LAT - 1));
        end
        chk("held_data", data_a, 8'hAA);
        chk("held_cnt", cnt_a, 1);

        // Random traffic against the model.
        step(1, 8'h00, 1, 0, 0);
        tog_v = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: tog_v = 8'h00;
                    1: tog_v = 8'hAA;
                    2: tog_v = 8'h55;
                    default: tog_v = 8'($urandom);
                endcase
            end
            step($urandom_range(0, 999) == 0, tog_v, $urandom_range(0, 7) != 0,
                 $urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
